// File: rtl/xbar_rr_scheduler_pkg.sv
// Shared crossbar types: destination-index width helper, per-output lock state, route index type.
package xbar_pkg;

    function automatic int route_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {XB_IDLE, XB_LOCKED} xb_state_e;

    localparam int XB_N_DEFAULT = 8;
    typedef logic [route_bits(XB_N_DEFAULT)-1:0] route_t;

endpackage

// File: rtl/xbar_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping to 0.
module rr_arbiter
    import xbar_pkg::*;
#(
    parameter int  N  = 8,
    localparam int RB = route_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [RB-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [RB-1:0] gnt_idx,
    output logic          any
);

    logic [N-1:0] upper;
    logic [N-1:0] pick;

    for (genvar i = 0; i < N; i++) begin : g_mask
        assign upper[i] = req[i] && (RB'(i) >= ptr);
    end

    // Requests at or above ptr take priority; otherwise fall back to the lowest request (wrap).
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = |req;
        pick    = (|upper) ? upper : req;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick[i]) gnt_idx = RB'(i);
        end
        if (any) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/xbar_rr_scheduler.sv
// Per-output round-robin crossbar scheduler with packet locking and registered select rows.
// Optional XBAR_HOLD_TIMEOUT_EN adds a per-output stall counter that forces release.
module xbar_rr_scheduler
    import xbar_pkg::*;
#(
    parameter int  N          = 8,
    parameter int  HOLD_MAX   = 16,
    localparam int ROUTE_BITS = route_bits(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req_valid,
    input  logic [ROUTE_BITS-1:0] req_dest [N],
    input  logic [N-1:0]          req_last,
    output logic [N-1:0]          req_ready,
    output logic [N-1:0]          select_SE [N],
    output logic [N-1:0]          out_busy,
    output logic [N-1:0]          timeout
);

    if (N < 2) begin : g_bad_n
        $error("xbar_rr_scheduler: N must be >= 2");
    end
    if (HOLD_MAX < 1) begin : g_bad_hold
        $error("xbar_rr_scheduler: HOLD_MAX must be >= 1");
    end

    logic [N-1:0] locked;
    logic [N-1:0] own_oh [N];

    for (genvar j = 0; j < N; j++) begin : g_out
        localparam logic [ROUTE_BITS-1:0] J = ROUTE_BITS'(j);

        logic [N-1:0]          cand;
        logic [N-1:0]          gnt;
        logic [ROUTE_BITS-1:0] gnt_idx;
        logic                  any;

        xb_state_e             state, state_nxt;
        logic [ROUTE_BITS-1:0] owner, owner_nxt;
        logic [ROUTE_BITS-1:0] ptr, ptr_nxt;
        logic [N-1:0]          oh, oh_nxt;
        logic                  xfer;
        logic                  expire;

        for (genvar i = 0; i < N; i++) begin : g_cand
            assign cand[i] = req_valid[i] && (req_dest[i] == J);
        end

        rr_arbiter #(.N(N)) u_arb (
            .req     (cand),
            .ptr     (ptr),
            .gnt     (gnt),
            .gnt_idx (gnt_idx),
            .any     (any)
        );

        assign xfer = (state == XB_LOCKED) && req_valid[owner] && (req_dest[owner] == J);

`ifdef XBAR_HOLD_TIMEOUT_EN
        localparam int CW = route_bits(HOLD_MAX);
        logic [CW-1:0] cnt;
        logic          to_q;

        assign expire = (state == XB_LOCKED) && !xfer && (cnt == CW'(HOLD_MAX - 1));

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt  <= '0;
                to_q <= 1'b0;
            end else begin
                to_q <= expire;
                if (state != XB_LOCKED || xfer || expire) cnt <= '0;
                else                                       cnt <= cnt + 1'b1;
            end
        end

        assign timeout[j] = to_q;
`else
        assign expire     = 1'b0;
        assign timeout[j] = 1'b0;
`endif

        always_comb begin
            state_nxt = state;
            owner_nxt = owner;
            oh_nxt    = oh;
            ptr_nxt   = ptr;
            case (state)
                XB_IDLE: begin
                    if (any) begin
                        state_nxt = XB_LOCKED;
                        owner_nxt = gnt_idx;
                        oh_nxt    = gnt;
                    end
                end
                XB_LOCKED: begin
                    if ((xfer && req_last[owner]) || expire) begin
                        state_nxt = XB_IDLE;
                        ptr_nxt   = (owner == ROUTE_BITS'(N - 1)) ? '0 : owner + 1'b1;
                    end
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= XB_IDLE;
                owner <= '0;
                oh    <= '0;
                ptr   <= '0;
            end else begin
                state <= state_nxt;
                owner <= owner_nxt;
                oh    <= oh_nxt;
                ptr   <= ptr_nxt;
            end
        end

        assign locked[j]    = (state == XB_LOCKED);
        assign own_oh[j]    = oh;
        assign out_busy[j]  = locked[j];
        assign select_SE[j] = locked[j] ? oh : '0;
    end

    // Ready only while the input still points at the output it owns.
    for (genvar i = 0; i < N; i++) begin : g_ready
        logic [N-1:0] hit;
        for (genvar j = 0; j < N; j++) begin : g_hit
            assign hit[j] = locked[j] && own_oh[j][i] && (req_dest[i] == ROUTE_BITS'(j));
        end
        assign req_ready[i] = |hit;
    end

endmodule
